// File: rtl/run_length_detector.sv
// -----------------------------------------------------------------------------
// run_length_detector
//
// Samples a serial bit stream on valid cycles and flags runs of RUN_LEN equal
// bits. The polarities that may raise the flag are chosen at run time through
// mode. OVERLAP is fixed at build time:
//   1: the flag stays up for as long as the run continues.
//   0: counting restarts after every detection, so a long run gives one
//      detection every RUN_LEN equal bits.
// The block also exposes the current (saturating) run length and a wrapping
// count of detection events.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-low reset
//   clr      in   1      synchronous clear of run state and evt_cnt (wins over w_valid)
//   w_valid  in   1      w is sampled only when high
//   w        in   1      serial data bit
//   mode     in   2      00 both polarities, 01 ones only, 10 zeros only, 11 off
//   z        out  1      registered level: current run qualifies
//   z_pol    out  1      polarity of the current run (last sampled bit)
//   hit      out  1      one-cycle pulse on each new detection
//   run_cnt  out  CNT_W  current run length, saturating at RUN_LEN
//   evt_cnt  out  EVT_W  number of hit pulses, wraps modulo 2^EVT_W
//
// Parameter legality (RUN_LEN in 2..255, 2^CNT_W-1 >= RUN_LEN) is the
// integrator's responsibility.
// -----------------------------------------------------------------------------
module run_length_detector #(
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned EVT_W   = 8,
  parameter bit          OVERLAP = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             w_valid,
  input  logic             w,
  input  logic [1:0]       mode,
  output logic             z,
  output logic             z_pol,
  output logic             hit,
  output logic [CNT_W-1:0] run_cnt,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);
  localparam logic [EVT_W-1:0] EVT_ZERO = EVT_W'(0);

  // EMPTY: no bit held since reset or clear. RUN: z_pol_r/run_cnt_r are valid.
  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Polarity enable decoded from mode.
  function automatic logic pol_en(input logic [1:0] m, input logic p);
    logic en;
    case (m)
      2'b00:   en = 1'b1;
      2'b01:   en = p;
      2'b10:   en = ~p;
      default: en = 1'b0;
    endcase
    return en;
  endfunction

  state_t           state_r, state_s;
  logic             z_pol_r, z_pol_s;
  logic [CNT_W-1:0] run_cnt_r, run_cnt_s;
  logic             restart_r, restart_s;
  logic             z_r, z_s;
  logic             hit_r, hit_s;
  logic [EVT_W-1:0] evt_cnt_r, evt_cnt_s;

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_EMPTY;
      z_pol_r   <= 1'b0;
      run_cnt_r <= CNT_ZERO;
      restart_r <= 1'b0;
      z_r       <= 1'b0;
      hit_r     <= 1'b0;
      evt_cnt_r <= EVT_ZERO;
    end else begin
      state_r   <= state_s;
      z_pol_r   <= z_pol_s;
      run_cnt_r <= run_cnt_s;
      restart_r <= restart_s;
      z_r       <= z_s;
      hit_r     <= hit_s;
      evt_cnt_r <= evt_cnt_s;
    end
  end

  // Next-state, run-length, detection and event-count logic.
  always_comb begin
    state_s   = state_r;
    z_pol_s   = z_pol_r;
    run_cnt_s = run_cnt_r;
    restart_s = restart_r;
    z_s       = 1'b0;
    hit_s     = 1'b0;
    evt_cnt_s = evt_cnt_r;

    if (clr) begin
      // Clear dominates; a sample presented in the same cycle is discarded.
      state_s   = ST_EMPTY;
      z_pol_s   = 1'b0;
      run_cnt_s = CNT_ZERO;
      restart_s = 1'b0;
      evt_cnt_s = EVT_ZERO;
    end else begin
      if (w_valid) begin
        // Any sample consumes a pending restart.
        restart_s = 1'b0;
        case (state_r)
          ST_EMPTY: begin
            state_s   = ST_RUN;
            z_pol_s   = w;
            run_cnt_s = CNT_ONE;
          end
          ST_RUN: begin
            if (w != z_pol_r) begin
              z_pol_s   = w;
              run_cnt_s = CNT_ONE;
            end else if (restart_r) begin
              // Non-overlapping mode: the first equal bit after a hit starts a fresh count.
              run_cnt_s = CNT_ONE;
            end else if (run_cnt_r >= RUN_MAX) begin
              run_cnt_s = RUN_MAX;
            end else begin
              run_cnt_s = run_cnt_r + CNT_ONE;
            end
          end
          default: begin
            state_s   = ST_EMPTY;
            run_cnt_s = CNT_ZERO;
          end
        endcase
      end else begin
        // No sample: run state holds; z is re-evaluated so mode changes still apply.
        run_cnt_s = run_cnt_r;
      end

      z_s   = (run_cnt_s == RUN_MAX) && pol_en(mode, z_pol_s);
      // A rising qualification is a new detection; with OVERLAP=0 z falls after every
      // hit, so this also covers each restarted run reaching RUN_LEN again.
      hit_s = z_s & ~z_r;

      if (hit_s) begin
        evt_cnt_s = evt_cnt_r + EVT_ONE;
        if (!OVERLAP) begin
          restart_s = 1'b1;
        end else begin
          restart_s = 1'b0;
        end
      end else begin
        evt_cnt_s = evt_cnt_r;
      end
    end
  end

  assign z       = z_r;
  assign z_pol   = z_pol_r;
  assign hit     = hit_r;
  assign run_cnt = run_cnt_r;
  assign evt_cnt = evt_cnt_r;

endmodule

// File: tb/tb_run_length_detector.sv
// -----------------------------------------------------------------------------
// tb_run_length_detector
//
// Two instances share one stimulus stream: dut0 with the default overlapping
// build (RUN_LEN=4, 8-bit event counter) and dut1 with OVERLAP=0 and a 4-bit
// event counter. A behavioural model tracks each instance from the run rules
// (unbounded run length, clipped for the readout) and every output is compared
// after every clock edge. Directed sequences cover the listed scenarios;
// a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_run_length_detector;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       w_valid;
  logic       w;
  logic [1:0] mode;

  logic       z0, z_pol0, hit0;
  logic [7:0] run_cnt0;
  logic [7:0] evt_cnt0;
  logic       z1, z_pol1, hit1;
  logic [2:0] run_cnt1;
  logic [3:0] evt_cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance.
  int unsigned p_rl  [2] = '{4, 4};
  bit          p_ov  [2] = '{1'b1, 1'b0};
  int unsigned p_emod[2] = '{256, 16};
  bit          m_has [2];
  bit          m_pol [2];
  int unsigned m_len [2];
  bit          m_z   [2];
  bit          m_hit [2];
  int unsigned m_evt [2];
  bit          m_rst [2];

  run_length_detector #(.RUN_LEN(4), .CNT_W(8), .EVT_W(8), .OVERLAP(1'b1)) dut0 (
    .clk(clk), .rst(rst), .clr(clr), .w_valid(w_valid), .w(w), .mode(mode),
    .z(z0), .z_pol(z_pol0), .hit(hit0), .run_cnt(run_cnt0), .evt_cnt(evt_cnt0)
  );

  run_length_detector #(.RUN_LEN(4), .CNT_W(3), .EVT_W(4), .OVERLAP(1'b0)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .w_valid(w_valid), .w(w), .mode(mode),
    .z(z1), .z_pol(z_pol1), .hit(hit1), .run_cnt(run_cnt1), .evt_cnt(evt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit enabled(input logic [1:0] m, input bit p);
    return (m == 2'd0) || (m == 2'd1 && p) || (m == 2'd2 && !p);
  endfunction

  function automatic int unsigned model_cnt(input int i);
    return (m_len[i] > p_rl[i]) ? p_rl[i] : m_len[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_has[i] = 1'b0; m_pol[i] = 1'b0; m_len[i] = 0; m_z[i] = 1'b0;
      m_hit[i] = 1'b0; m_evt[i] = 0;    m_rst[i] = 1'b0;
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  task automatic model_step();
    bit nz;
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_has[i] = 1'b0; m_pol[i] = 1'b0; m_len[i] = 0; m_z[i] = 1'b0;
        m_hit[i] = 1'b0; m_evt[i] = 0;    m_rst[i] = 1'b0;
      end else begin
        if (w_valid) begin
          if (!m_has[i] || w != m_pol[i]) begin
            m_len[i] = 1; m_pol[i] = w; m_has[i] = 1'b1;
          end else if (m_rst[i]) begin
            m_len[i] = 1;
          end else begin
            m_len[i] = m_len[i] + 1;
          end
          m_rst[i] = 1'b0;
        end
        nz = (model_cnt(i) == p_rl[i]) && enabled(mode, m_pol[i]);
        m_hit[i] = nz && !m_z[i];
        m_z[i] = nz;
        if (m_hit[i]) begin
          m_evt[i] = (m_evt[i] + 1) % p_emod[i];
          if (!p_ov[i]) m_rst[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    check_eq("d0.z",       z0,       m_z[0]);
    check_eq("d0.z_pol",   z_pol0,   m_pol[0]);
    check_eq("d0.hit",     hit0,     m_hit[0]);
    check_eq("d0.run_cnt", run_cnt0, model_cnt(0));
    check_eq("d0.evt_cnt", evt_cnt0, m_evt[0]);
    check_eq("d1.z",       z1,       m_z[1]);
    check_eq("d1.z_pol",   z_pol1,   m_pol[1]);
    check_eq("d1.hit",     hit1,     m_hit[1]);
    check_eq("d1.run_cnt", run_cnt1, model_cnt(1));
    check_eq("d1.evt_cnt", evt_cnt1, m_evt[1]);
  endtask

  // Present one input cycle, let the edge happen, then compare 1 ns later.
  task automatic tick(input logic v, input logic b);
    w_valid = v;
    w = b;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick(1'b0, 1'b0);
    clr = 1'b0;
  endtask

  initial begin
    int hits;
    logic b;
    bit seq5 [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b0; clr = 1'b0; w_valid = 1'b0; w = 1'b0; mode = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all();
    rst = 1'b1;

    // 1: four valid zeros, both polarities.
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    check_eq("t1.z", z0, 1);
    check_eq("t1.hit", hit0, 1);
    check_eq("t1.run_cnt", run_cnt0, 4);
    check_eq("t1.evt_cnt", evt_cnt0, 1);

    // 2: six ones, overlapping build keeps z up and hits once.
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, 1'b1);
      hits += int'(hit0);
      if (i >= 3) check_eq("t2.z_held", z0, 1);
    end
    check_eq("t2.hits", hits, 1);
    check_eq("t2.run_cnt", run_cnt0, 4);

    // 3: eight ones, non-overlapping build restarts after each hit.
    do_clear();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1);
      check_eq("t3.run_cnt", run_cnt1, (i % 4) + 1);
      check_eq("t3.hit", hit1, (i % 4) == 3 ? 1 : 0);
    end
    check_eq("t3.evt_cnt", evt_cnt1, 2);

    // 4: ones-only mode ignores a zero run; enabling zeros raises z with one hit.
    do_clear();
    mode = 2'b01;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check_eq("t4.z_off", z0, 0);
    check_eq("t4.evt_off", evt_cnt0, 0);
    mode = 2'b00;
    tick(1'b0, 1'b0);
    check_eq("t4.z_on", z0, 1);
    check_eq("t4.hit_on", hit0, 1);
    tick(1'b0, 1'b0);
    check_eq("t4.hit_once", hit0, 0);
    // Disabling drops z without a hit.
    mode = 2'b11;
    tick(1'b0, 1'b0);
    check_eq("t4.z_drop", z0, 0);
    check_eq("t4.no_hit", hit0, 0);
    mode = 2'b00;

    // 5: broken run then four ones, with invalid cycles between samples.
    do_clear();
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, seq5[i]);
      hits += int'(hit0);
      if (i == 3) check_eq("t5.reset_cnt", run_cnt0, 1);
      tick(1'b0, ~seq5[i]);
      hits += int'(hit0);
    end
    check_eq("t5.hits", hits, 1);
    check_eq("t5.evt", evt_cnt0, 1);

    // 6: asynchronous reset mid-run, between edges.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("t6.arst_cnt", run_cnt0, 0);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    clr = 1'b1;
    tick(1'b1, 1'b1);
    clr = 1'b0;
    check_eq("t6.clr_evt", evt_cnt0, 0);
    check_eq("t6.clr_cnt", run_cnt0, 0);

    // Event counter wrap: 256 hits on dut0 (and 256 on dut1, mod 16).
    for (int k = 0; k < 128; k++) begin
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    end
    check_eq("wrap.evt0", evt_cnt0, 0);
    check_eq("wrap.evt1", evt_cnt1, 0);

    // Randomized phase.
    b = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b = ~b;
      tick($urandom_range(0, 3) != 0, b);
    end
    clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
